// File: rtl/dbscan_run_cluster.sv
// 1-D DBSCAN run clusterer: groups sorted samples into eps-connected runs, counts clusters/noise per frame.
// Optional max-cluster-size tracking is enabled by defining DBSCAN_MAXSIZE_EN.
module dbscan_run_cluster #(
    parameter int DW = 10,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] cfg_eps,
    input  logic [CW-1:0] cfg_minpts,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          busy,
    output logic          out_valid,
    output logic [CW-1:0] out_clusters,
    output logic [CW-1:0] out_noise,
    output logic [CW-1:0] out_max_size
);

    typedef enum logic [1:0] {IDLE, FIRST, RUN, REPORT} state_t;

    typedef struct packed {
        logic [CW-1:0] clusters;
        logic [CW-1:0] noise;
`ifdef DBSCAN_MAXSIZE_EN
        logic [CW-1:0] max_size;
`endif
    } stats_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    function automatic logic [CW-1:0] sat_add(logic [CW-1:0] a, logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? CNT_MAX : s[CW-1:0];
    endfunction

    // A finished run is either a cluster (length >= minpts) or all of its points are noise.
    function automatic stats_t close_run(stats_t s, logic [CW-1:0] len, logic [CW-1:0] minpts);
        stats_t r;
        r = s;
        if (len >= minpts) begin
            r.clusters = sat_add(s.clusters, CW'(1));
`ifdef DBSCAN_MAXSIZE_EN
            if (len > s.max_size) r.max_size = len;
`endif
        end else begin
            r.noise = sat_add(s.noise, len);
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] eps_q, eps_d;
    logic [CW-1:0] minpts_q, minpts_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [CW-1:0] run_len_q, run_len_d;
    stats_t        stats_q, stats_d;
    stats_t        result_q, result_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;

    logic [DW:0]   diff;
    logic [CW-1:0] len_next;
    stats_t        st;
    logic          finish;

    // Absolute difference in DW+1 bits so unsorted input never wraps.
    assign diff = (in_data >= prev_q) ? ({1'b0, in_data} - {1'b0, prev_q})
                                      : ({1'b0, prev_q} - {1'b0, in_data});

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred on untaken paths.
        state_d     = state_q;
        eps_d       = eps_q;
        minpts_d    = minpts_q;
        prev_d      = prev_q;
        run_len_d   = run_len_q;
        stats_d     = stats_q;
        result_d    = result_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        len_next    = run_len_q;
        st          = stats_q;
        finish      = 1'b0;

        if (start) begin
            eps_d     = cfg_eps;
            minpts_d  = (cfg_minpts == '0) ? CW'(1) : cfg_minpts;
            run_len_d = '0;
            stats_d   = '0;
            state_d   = FIRST;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                FIRST: if (in_valid) begin
                    prev_d    = in_data;
                    run_len_d = CW'(1);
                    state_d   = RUN;
                    if (in_last) begin
                        stats_d = close_run(stats_q, CW'(1), minpts_q);
                        finish  = 1'b1;
                    end
                end
                RUN: if (in_valid) begin
                    prev_d = in_data;
                    if (diff <= {1'b0, eps_q}) begin
                        len_next = sat_add(run_len_q, CW'(1));
                    end else begin
                        st       = close_run(stats_q, run_len_q, minpts_q);
                        len_next = CW'(1);
                    end
                    // The last sample may both end one run and form a new one-point run.
                    if (in_last) begin
                        st     = close_run(st, len_next, minpts_q);
                        finish = 1'b1;
                    end
                    run_len_d = len_next;
                    stats_d   = st;
                end
                REPORT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (finish) begin
                state_d     = REPORT;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                result_d    = stats_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            eps_q       <= '0;
            minpts_q    <= '0;
            prev_q      <= '0;
            run_len_q   <= '0;
            stats_q     <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q     <= state_d;
            eps_q       <= eps_d;
            minpts_q    <= minpts_d;
            prev_q      <= prev_d;
            run_len_q   <= run_len_d;
            stats_q     <= stats_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy         = busy_q;
    assign out_valid    = out_valid_q;
    assign out_clusters = result_q.clusters;
    assign out_noise    = result_q.noise;
`ifdef DBSCAN_MAXSIZE_EN
    assign out_max_size = result_q.max_size;
`else
    assign out_max_size = '0;
`endif

endmodule

// File: tb/tb_dbscan_run_cluster.sv
// Randomised bench for dbscan_run_cluster: two instances (CW=10 and CW=4) against a run-list reference model.
module tb_dbscan_run_cluster;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic [DW-1:0] cfg_eps, in_data;
    logic [9:0]    cfg_minpts;

    logic       busy10, valid10;
    logic [9:0] cl10, nz10, mx10;
    logic       busy4, valid4;
    logic [3:0] cl4, nz4, mx4;

    int n_checks = 0;
    int n_pass = 0;
    int pulses10 = 0, pulses4 = 0, exp_pulses = 0, dbl = 0;
    bit prev_valid = 1'b0;
    bit max_en;

    dbscan_run_cluster #(.DW(DW), .CW(10)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_eps(cfg_eps), .cfg_minpts(cfg_minpts),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .busy(busy10),
        .out_valid(valid10), .out_clusters(cl10), .out_noise(nz10), .out_max_size(mx10)
    );

    dbscan_run_cluster #(.DW(DW), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .cfg_eps(cfg_eps), .cfg_minpts(cfg_minpts[3:0]),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .busy(busy4),
        .out_valid(valid4), .out_clusters(cl4), .out_noise(nz4), .out_max_size(mx4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid10) pulses10++;
        if (valid4) pulses4++;
        if (valid10 && prev_valid) dbl++;
        prev_valid = valid10;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: split the sample list into eps-connected runs, then classify each run.
    task automatic model(input int s[$], input int eps, input int minpts, input int cap,
                         output int cl, output int nz, output int mx);
        int runs[$];
        int mp, len, d;
        mp = (minpts == 0) ? 1 : minpts;
        foreach (s[i]) begin
            d = (i == 0) ? 0 : ((s[i] > s[i-1]) ? s[i] - s[i-1] : s[i-1] - s[i]);
            if (i == 0 || d > eps) runs.push_back(1);
            else runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
        cl = 0; nz = 0; mx = 0;
        foreach (runs[k]) begin
            len = (runs[k] > cap) ? cap : runs[k];
            if (len >= mp) begin
                cl++;
                if (len > mx) mx = len;
            end else begin
                nz += len;
            end
        end
        if (cl > cap) cl = cap;
        if (nz > cap) nz = cap;
        if (!max_en) mx = 0;
    endtask

    // Starts a frame, feeds it with `gap` idle cycles before each sample, and checks the report.
    // Returns during the report cycle so a caller can start the next frame immediately.
    task automatic drive_frame(input int s[$], input int eps, input int minpts, input int gap,
                               input string tag);
        int cl, nz, mx;
        cfg_eps    = DW'(eps);
        cfg_minpts = 10'(minpts);
        start      = 1'b1;
        in_valid   = 1'($urandom_range(0, 1));
        in_data    = DW'($urandom);
        in_last    = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check({tag, "_busy"}, int'(busy10), 1);
        foreach (s[i]) begin
            repeat (gap) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = DW'(s[i]);
            in_last  = (i == s.size() - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_pulses++;
        model(s, eps, minpts, 1023, cl, nz, mx);
        check({tag, "_valid"}, int'(valid10), 1);
        check({tag, "_clusters"}, int'(cl10), cl);
        check({tag, "_noise"}, int'(nz10), nz);
        check({tag, "_max"}, int'(mx10), mx);
        model(s, eps, minpts % 16, 15, cl, nz, mx);
        check({tag, "_valid4"}, int'(valid4), 1);
        check({tag, "_clusters4"}, int'(cl4), cl);
        check({tag, "_noise4"}, int'(nz4), nz);
        check({tag, "_max4"}, int'(mx4), mx);
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, "_valid_drop"}, int'(valid10), 0);
        check({tag, "_busy_drop"}, int'(busy10), 0);
    endtask

    task automatic feed_partial(input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = DW'(100 + 3 * i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int s[$];
        int p0, len, v, eps, mp, mode;
`ifdef DBSCAN_MAXSIZE_EN
        max_en = 1'b1;
`else
        max_en = 1'b0;
`endif
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; cfg_eps = '0; cfg_minpts = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy10), 0);
        check("rst_valid", int'(valid10), 0);
        check("rst_clusters", int'(cl10), 0);
        check("rst_noise", int'(nz10), 0);
        check("rst_max", int'(mx10), 0);
        reset = 1'b0;
        tick();

        s = '{10, 11, 12, 20, 21, 30, 31, 32, 33};
        drive_frame(s, 2, 3, 0, "t1");
        check("t1_clusters_const", int'(cl10), 2);
        check("t1_noise_const", int'(nz10), 2);
        check("t1_max_const", int'(mx10), max_en ? 4 : 0);
        idle_check("t1");

        s = '{5};
        drive_frame(s, 0, 1, 0, "t2a");
        idle_check("t2a");
        drive_frame(s, 0, 0, 1, "t2b");
        idle_check("t2b");

        s.delete();
        repeat (20) s.push_back(7);
        drive_frame(s, 0, 2, 0, "t3");
        check("t3_max4_sat", int'(mx4), max_en ? 15 : 0);
        idle_check("t3");

        s = '{40, 38, 30, 29, 10};
        drive_frame(s, 3, 2, 0, "t4");
        idle_check("t4");

        p0 = pulses10;
        feed_partial(3);
        s = '{1, 2, 3};
        drive_frame(s, 1, 2, 0, "t5");
        idle_check("t5");
        check("t5_one_pulse", pulses10 - p0, 1);

        p0 = pulses10;
        feed_partial(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy", int'(busy10), 0);
        check("t6_clusters", int'(cl10), 0);
        check("t6_noise", int'(nz10), 0);
        check("t6_max", int'(mx10), 0);
        check("t6_clusters4", int'(cl4), 0);
        tick();
        check("t6_no_pulse", pulses10 - p0, 0);
        s = '{10, 11, 12, 20, 21, 30, 31, 32, 33};
        drive_frame(s, 2, 3, 3, "t6_gap");
        idle_check("t6_gap");

        // Start asserted during the report cycle chains straight into the next frame.
        s = '{50, 51, 60};
        drive_frame(s, 1, 2, 0, "t7a");
        s = '{9, 9, 9, 300};
        drive_frame(s, 0, 3, 0, "t7b");
        idle_check("t7");

        for (int f = 0; f < 30; f++) begin
            s.delete();
            len  = $urandom_range(1, 12);
            v    = $urandom_range(0, 1023);
            for (int i = 0; i < len; i++) begin
                mode = $urandom_range(0, 5);
                if (mode == 0) v = $urandom_range(0, 1023);
                else if (mode < 3) v = (v >= 6) ? v - $urandom_range(0, 6) : v;
                else v = (v <= 1017) ? v + $urandom_range(0, 6) : v;
                s.push_back(v);
            end
            eps = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 4);
            mp  = $urandom_range(0, 4);
            drive_frame(s, eps, mp, $urandom_range(0, 2), $sformatf("rnd%0d", f));
            if ($urandom_range(0, 2) != 0) idle_check($sformatf("rnd%0d", f));
        end
        idle_check("end");
        tick();

        check("pulse_count", pulses10, exp_pulses);
        check("pulse_count4", pulses4, exp_pulses);
        check("no_double_pulse", dbl, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dbscan_run_cluster.md
Name: dbscan_run_cluster

Overview:
Parametrised 1-D DBSCAN cluster counter for sorted magnitude streams from the shift-register chain.
- Groups consecutive samples whose absolute difference is at most epsilon into runs.
- Classifies each run as a cluster (length >= minpts) or noise.
- Reports per frame: cluster count, noise-point count and largest cluster size, with a valid pulse.
- Epsilon and minpts are runtime inputs, latched per frame.

Parameters:
DW, 10, sample data width (bits)
CW, 10, width of all counters and count outputs (bits); all counters saturate at 2^CW-1

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  frame start pulse; latches cfg_eps and cfg_minpts, clears counters
cfg_eps  input  DW  epsilon, same LSB scaling as in_data
cfg_minpts  input  CW  minimum points per cluster; 0 is treated as 1
in_valid  input  1  sample qualifier
in_data  input  DW  sample, unsigned
in_last  input  1  marks final sample of frame; qualified by in_valid
busy  output  1  high while a frame is in progress
out_valid  output  1  one-cycle pulse; result outputs updated on this cycle
out_clusters  output  CW  number of clusters in last frame
out_noise  output  CW  number of noise points in last frame
out_max_size  output  CW  point count of largest cluster in last frame

Behaviour:
- States: IDLE, FIRST, RUN, REPORT.
- Reset:
  - State goes to IDLE.
  - busy, out_valid, out_clusters, out_noise and out_max_size all 0.
  - Internal counters and the previous-sample register cleared.
- start in any state, reset low:
  - Latch cfg_eps, and cfg_minpts (0 replaced by 1).
  - Clear run_len, clusters, noise and max.
  - Go to FIRST; busy=1.
  - Any in_valid on the start cycle is ignored.
  - start during FIRST/RUN aborts the frame silently (no out_valid). Result outputs keep their old values.
- IDLE: in_valid ignored.
- FIRST, on in_valid:
  - prev<=in_data; run_len<=1; go to RUN.
  - If in_last is also high, close the run (see below) and go to REPORT.
- RUN, on in_valid:
  - d = |in_data - prev|, computed in DW+1 bits with no wrap.
  - If d <= eps_l: run_len += 1, saturating.
  - Otherwise: close the current run, then run_len<=1.
  - prev<=in_data on every accepted sample.
  - Descending or unsorted input is legal; the absolute difference is used.
- Closing a run:
  - If run_len >= minpts_l: clusters += 1 (saturating); max <= max(max, run_len).
  - Otherwise: noise += run_len (saturating).
- in_last with in_valid in RUN:
  - Process the sample as above, then close the resulting final run in the same cycle.
  - The final run includes the last sample.
  - Go to REPORT.
- REPORT (one cycle):
  - out_valid=1; out_* <= internal counters.
  - busy drops to 0; next state IDLE.
  - Latency: out_valid is asserted 1 cycle after the in_last sample is accepted.
  - start during REPORT: the report still completes this cycle, and the new frame begins (FIRST) next cycle.
- in_valid gaps: allowed anywhere in FIRST/RUN; no timeout.
- Outputs hold between reports; out_valid is never asserted for two consecutive cycles.
- Reset mid-frame: immediate return to IDLE, all outputs 0, no report.

Optional Feature:
DBSCAN_MAXSIZE_EN
- Defined: max-size tracking logic present; out_max_size behaves as above.
- Undefined: tracking register and comparator removed; out_max_size is tied to 0. All other behaviour is identical.

Test Plan:
1. eps=2, minpts=3, samples 10,11,12,20,21,30,31,32,33 (last on 33) -> out_valid 1 cycle after 33; clusters=2, noise=2, max=4.
2. eps=0, minpts=1, single sample 5 with in_last on first valid -> clusters=1, noise=0, max=1; cfg_minpts=0 gives the same result.
3. CW=4, eps=0, minpts=2, twenty samples of 7 -> clusters=1, noise=0, max=15 (saturated).
4. eps=3, minpts=2, descending 40,38,30,29,10 -> clusters=2, noise=1, max=2.
5. Start frame, feed 3 samples, assert start again, then feed 1,2,3 (last), eps=1, minpts=2 -> exactly one out_valid; clusters=1, noise=0, max=3.
6. Reset asserted mid-frame after 4 samples -> busy=0, all outputs 0, no out_valid; a following frame reports correctly. Also check in_valid gaps of 3 idle cycles between samples leave results unchanged.
